pacman_mover: RTL

PACMAN_MOVER -- requirements
Module: pacman_mover

---
 rtl/pacman_pkg.sv | 43 ++++
 rtl/pacman_mover_btn_sync.sv | 33 +++
 rtl/pacman_mover.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/pacman_pkg.sv
// Shared types and grid constants for the pacman sprite mover.
package pacman_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEFT  = 3'd1,
        RIGHT = 3'd2,
        UP    = 3'd3,
        DOWN  = 3'd4
    } dir_t;

    localparam int GRID_X0  = 150;
    localparam int GRID_Y0  = 34;
    localparam int TILE_PX  = 60;
    localparam int GRID_DIM = 8;

    // Direction that undoes the given one; IDLE has no opposite.
    function automatic dir_t opposite_dir(input dir_t d);
        dir_t o;
        case (d)
            LEFT:    o = RIGHT;
            RIGHT:   o = LEFT;
            UP:      o = DOWN;
            DOWN:    o = UP;
            default: o = IDLE;
        endcase
        return o;
    endfunction

    // Pick the legal-move flag that matches a direction; leg is {l, r, u, d}.
    function automatic logic dir_legal(input dir_t d, input logic [3:0] leg);
        logic ok;
        case (d)
            LEFT:    ok = leg[3];
            RIGHT:   ok = leg[2];
            UP:      ok = leg[1];
            DOWN:    ok = leg[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/pacman_mover_btn_sync.sv
// Two-flop synchronizer bringing the four raw player buttons into the clk domain.
module btn_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn_raw,
    output logic [3:0] btn_out
);

    logic [3:0] meta_q;
    logic [3:0] meta_d;
    logic [3:0] sync_q;
    logic [3:0] sync_d;

    // Next values simply shift the raw buttons one stage down the chain.
    always_comb begin
        meta_d = btn_raw;
        sync_d = meta_q;
    end

    // Synchronizer stages, cleared by reset so no stale press survives it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 4'b0000;
            sync_q <= 4'b0000;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign btn_out = sync_q;

endmodule

// File: rtl/pacman_mover.sv
// Tile-grid sprite mover: queues the player's requested direction and walks
// the sprite STEP pixels per frame, turning only on tile-aligned positions.
module pacman_mover #(
    parameter int STEP      = 2,
    parameter int START_COL = 1,
    parameter int START_ROW = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       l,
    input  logic       r,
    input  logic       u,
    input  logic       d,
    input  logic       leg_l,
    input  logic       leg_r,
    input  logic       leg_u,
    input  logic       leg_d,
    output logic [9:0] xpos,
    output logic [9:0] ypos,
    output logic [2:0] tile_col,
    output logic [2:0] tile_row,
    output logic [2:0] dir,
    output logic       aligned
);

    import pacman_pkg::*;

    localparam logic [5:0] STEP_W   = 6'(STEP);
    localparam logic [5:0] LAST_OFF = 6'(TILE_PX - STEP);
    localparam logic [2:0] MAX_IDX  = 3'(GRID_DIM - 1);
    localparam logic [2:0] COL_RST  = 3'(START_COL);
    localparam logic [2:0] ROW_RST  = 3'(START_ROW);
    localparam logic [9:0] XPOS_RST = 10'(GRID_X0 + TILE_PX * START_COL);
    localparam logic [9:0] YPOS_RST = 10'(GRID_Y0 + TILE_PX * START_ROW);

    logic [3:0] btn_s;
    logic [3:0] leg;

    dir_t       state_q, state_d;
    dir_t       queue_q, queue_d;
    dir_t       cand;
    logic [2:0] col_q, col_d;
    logic [2:0] row_q, row_d;
    logic [5:0] x_off_q, x_off_d;
    logic [5:0] y_off_q, y_off_d;
    logic [9:0] xpos_q, xpos_d;
    logic [9:0] ypos_q, ypos_d;
    logic       at_tile;

    btn_sync u_btn_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw ({l, r, u, d}),
        .btn_out (btn_s)
    );

    assign leg     = {leg_l, leg_r, leg_u, leg_d};
    assign at_tile = (x_off_q == 6'd0) && (y_off_q == 6'd0);

    // Any synchronized press overwrites the queued direction, left winning ties.
    always_comb begin
        queue_d = queue_q;
        if (btn_s[3]) begin
            queue_d = LEFT;
        end else if (btn_s[2]) begin
            queue_d = RIGHT;
        end else if (btn_s[1]) begin
            queue_d = UP;
        end else if (btn_s[0]) begin
            queue_d = DOWN;
        end
    end

    // Per-tick movement decision and one STEP of travel, refusing to leave the grid.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        x_off_d = x_off_q;
        y_off_d = y_off_q;
        cand    = IDLE;
        if (frame_tick) begin
            if (at_tile) begin
                if (queue_q != IDLE && dir_legal(queue_q, leg)) begin
                    cand = queue_q;
                end else if (state_q != IDLE && dir_legal(state_q, leg)) begin
                    cand = state_q;
                end else begin
                    cand = IDLE;
                end
            end else begin
                if (state_q != IDLE && queue_q == opposite_dir(state_q)) begin
                    cand = queue_q;
                end else begin
                    cand = state_q;
                end
            end
            state_d = cand;
            case (cand)
                RIGHT: begin
                    if (x_off_q == LAST_OFF) begin
                        if (col_q == MAX_IDX) begin
                            state_d = IDLE;
                        end else begin
                            col_d   = col_q + 3'd1;
                            x_off_d = 6'd0;
                        end
                    end else begin
                        x_off_d = x_off_q + STEP_W;
                    end
                end
                LEFT: begin
                    if (x_off_q == 6'd0) begin
                        if (col_q == 3'd0) begin
                            state_d = IDLE;
                        end else begin
                            col_d   = col_q - 3'd1;
                            x_off_d = LAST_OFF;
                        end
                    end else begin
                        x_off_d = x_off_q - STEP_W;
                    end
                end
                DOWN: begin
                    if (y_off_q == LAST_OFF) begin
                        if (row_q == MAX_IDX) begin
                            state_d = IDLE;
                        end else begin
                            row_d   = row_q + 3'd1;
                            y_off_d = 6'd0;
                        end
                    end else begin
                        y_off_d = y_off_q + STEP_W;
                    end
                end
                UP: begin
                    if (y_off_q == 6'd0) begin
                        if (row_q == 3'd0) begin
                            state_d = IDLE;
                        end else begin
                            row_d   = row_q - 3'd1;
                            y_off_d = LAST_OFF;
                        end
                    end else begin
                        y_off_d = y_off_q - STEP_W;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Screen coordinates follow from the next tile and offset so they stay in step with them.
    always_comb begin
        xpos_d = 10'(GRID_X0) + 10'(col_d) * 10'(TILE_PX) + 10'(x_off_d);
        ypos_d = 10'(GRID_Y0) + 10'(row_d) * 10'(TILE_PX) + 10'(y_off_d);
    end

    // Mover FSM and position registers; reset parks the sprite on the start tile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            queue_q <= IDLE;
            col_q   <= COL_RST;
            row_q   <= ROW_RST;
            x_off_q <= 6'd0;
            y_off_q <= 6'd0;
            xpos_q  <= XPOS_RST;
            ypos_q  <= YPOS_RST;
        end else begin
            state_q <= state_d;
            queue_q <= queue_d;
            col_q   <= col_d;
            row_q   <= row_d;
            x_off_q <= x_off_d;
            y_off_q <= y_off_d;
            xpos_q  <= xpos_d;
            ypos_q  <= ypos_d;
        end
    end

    assign xpos     = xpos_q;
    assign ypos     = ypos_q;
    assign tile_col = col_q;
    assign tile_row = row_q;
    assign dir      = state_q;
    assign aligned  = at_tile;

endmodule
